// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline register placed between two processor stages. On every rising
// edge it sorts the stall/flush inputs into one of four actions and updates
// the payload, the multi-cycle carry state and two statistics counters.
//
// Edge action, highest priority first:
//   FLUSH   (flush_i)                    payload <- NOP, valid <- 0, carry <- 0
//   BUBBLE  (stall_up & !stall_dn)       payload <- NOP, valid <- 0, carry <- carry_i
//   ADVANCE (!stall_up & !stall_dn)      payload <- in_data, valid <- in_valid, carry <- 0
//   HOLD    (stall_dn)                   payload/valid kept,             carry <- carry_i
//
// A HOLD with stall_up=0 means the downstream stage is stalled while the
// upstream stage still believes it can push; the payload is held, and the
// sticky err_o flag is raised.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset
//   in_data    in   DATA_W   payload from upstream stage
//   in_valid   in   1        payload qualifies a real instruction
//   stall_up   in   1        upstream stage stalled
//   stall_dn   in   1        downstream stage stalled
//   flush_i    in   1        exception / redirect flush
//   carry_i    in   CARRY_W  multi-cycle operation state from upstream
//   cnt_clr_i  in   1        synchronous clear of counters and err_o
//   out_data   out  DATA_W   registered payload
//   out_valid  out  1        registered valid
//   carry_o    out  CARRY_W  registered carry state returned upstream
//   bubble_cnt out  CNT_W    saturating count of BUBBLE edges
//   hold_cnt   out  CNT_W    saturating count of HOLD edges
//   err_o      out  1        sticky illegal-stall-combination flag
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                 DATA_W    = 140,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter int                 CARRY_W   = 66,
    parameter bit                 CARRY_EN  = 1'b1,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               stall_up,
    input  logic               stall_dn,
    input  logic               flush_i,
    input  logic [CARRY_W-1:0] carry_i,
    input  logic               cnt_clr_i,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic [CARRY_W-1:0] carry_o,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic               err_o
);

    typedef enum logic [1:0] {
        ACT_FLUSH   = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_ADVANCE = 2'd2,
        ACT_HOLD    = 2'd3
    } act_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    act_t               act;
    logic               illegal_stall;
    logic [DATA_W-1:0]  data_nxt;
    logic               valid_nxt;
    logic [CARRY_W-1:0] carry_nxt;
    logic [CNT_W-1:0]   bubble_nxt;
    logic [CNT_W-1:0]   hold_nxt;
    logic               err_nxt;

    // ------------------------------------------------------------------
    // Edge classification
    // ------------------------------------------------------------------
    always_comb begin
        act = ACT_HOLD;
        if (flush_i) begin
            act = ACT_FLUSH;
        end else if (stall_up && !stall_dn) begin
            act = ACT_BUBBLE;
        end else if (!stall_up && !stall_dn) begin
            act = ACT_ADVANCE;
        end else begin
            act = ACT_HOLD;
        end
    end

    // Only a genuine HOLD edge can be illegal; a flush wins over it.
    assign illegal_stall = (act == ACT_HOLD) && !stall_up;

    // ------------------------------------------------------------------
    // Payload / carry next state
    // ------------------------------------------------------------------
    always_comb begin
        data_nxt  = out_data;
        valid_nxt = out_valid;
        carry_nxt = '0;
        case (act)
            ACT_FLUSH: begin
                data_nxt  = NOP_VALUE;
                valid_nxt = 1'b0;
                carry_nxt = '0;
            end
            ACT_BUBBLE: begin
                data_nxt  = NOP_VALUE;
                valid_nxt = 1'b0;
                carry_nxt = carry_i;
            end
            ACT_ADVANCE: begin
                data_nxt  = in_data;
                valid_nxt = in_valid;
                carry_nxt = '0;
            end
            ACT_HOLD: begin
                data_nxt  = out_data;
                valid_nxt = out_valid;
                carry_nxt = carry_i;
            end
            default: begin
                data_nxt  = out_data;
                valid_nxt = out_valid;
                carry_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Statistics next state. The clear wins over any increment or error
    // raised on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        bubble_nxt = bubble_cnt;
        hold_nxt   = hold_cnt;
        err_nxt    = err_o;
        if (cnt_clr_i) begin
            bubble_nxt = '0;
            hold_nxt   = '0;
            err_nxt    = 1'b0;
        end else begin
            if ((act == ACT_BUBBLE) && (bubble_cnt != CNT_MAX)) begin
                bubble_nxt = bubble_cnt + 1'b1;
            end
            if ((act == ACT_HOLD) && (hold_cnt != CNT_MAX)) begin
                hold_nxt = hold_cnt + 1'b1;
            end
            if (illegal_stall) begin
                err_nxt = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= NOP_VALUE;
            out_valid <= 1'b0;
        end else begin
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
            err_o      <= 1'b0;
        end else begin
            bubble_cnt <= bubble_nxt;
            hold_cnt   <= hold_nxt;
            err_o      <= err_nxt;
        end
    end

    // The carry register only exists when multi-cycle operations are used.
    generate
        if (CARRY_EN) begin : g_carry
            logic [CARRY_W-1:0] carry_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    carry_q <= '0;
                end else begin
                    carry_q <= carry_nxt;
                end
            end
            assign carry_o = carry_q;
        end else begin : g_no_carry
            logic unused_carry;
            assign unused_carry = ^{carry_nxt, carry_i};
            assign carry_o      = '0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. Two instances share the stimulus:
//   dut   : default parameters (140-bit payload, 66-bit carry, 16-bit counters)
//   dut_s : 8-bit payload, NOP_VALUE=8'hA5, CARRY_EN=0, 4-bit counters
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DW = 140;
    localparam int CW = 66;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          stall_up;
    logic          stall_dn;
    logic          flush_i;
    logic [CW-1:0] carry_i;
    logic          cnt_clr_i;

    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [CW-1:0] carry_o;
    logic [15:0]   bubble_cnt;
    logic [15:0]   hold_cnt;
    logic          err_o;

    logic [7:0]    s_out_data;
    logic          s_out_valid;
    logic [CW-1:0] s_carry_o;
    logic [3:0]    s_bubble_cnt;
    logic [3:0]    s_hold_cnt;
    logic          s_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_reg dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .stall_up   (stall_up),
        .stall_dn   (stall_dn),
        .flush_i    (flush_i),
        .carry_i    (carry_i),
        .cnt_clr_i  (cnt_clr_i),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .carry_o    (carry_o),
        .bubble_cnt (bubble_cnt),
        .hold_cnt   (hold_cnt),
        .err_o      (err_o)
    );

    pipe_stage_reg #(
        .DATA_W    (8),
        .NOP_VALUE (8'hA5),
        .CARRY_W   (CW),
        .CARRY_EN  (1'b0),
        .CNT_W     (4)
    ) dut_s (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data[7:0]),
        .in_valid   (in_valid),
        .stall_up   (stall_up),
        .stall_dn   (stall_dn),
        .flush_i    (flush_i),
        .carry_i    (carry_i),
        .cnt_clr_i  (cnt_clr_i),
        .out_data   (s_out_data),
        .out_valid  (s_out_valid),
        .carry_o    (s_carry_o),
        .bubble_cnt (s_bubble_cnt),
        .hold_cnt   (s_hold_cnt),
        .err_o      (s_err_o)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic su, input logic sd, input logic fl,
                         input logic [DW-1:0] d, input logic v,
                         input logic [CW-1:0] c, input logic clr);
        stall_up  = su;
        stall_dn  = sd;
        flush_i   = fl;
        in_data   = d;
        in_valid  = v;
        carry_i   = c;
        cnt_clr_i = clr;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data"},    out_data,     '0);
        chk({tag, "_valid"},   out_valid,    1'b0);
        chk({tag, "_carry"},   carry_o,      '0);
        chk({tag, "_bubble"},  bubble_cnt,   '0);
        chk({tag, "_hold"},    hold_cnt,     '0);
        chk({tag, "_err"},     err_o,        1'b0);
        chk({tag, "_s_data"},  s_out_data,   8'hA5);
        chk({tag, "_s_valid"}, s_out_valid,  1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);

        // Reset state, before any clock edge.
        #2;
        chk_reset_state("reset");
        #1 rst = 1'b0;

        // First edge after reset is a normal ADVANCE.
        drive(1'b0, 1'b0, 1'b0, 140'h1234_5678, 1'b1, '0, 1'b0);
        step();
        chk("adv_data",  out_data,  140'h1234_5678);
        chk("adv_valid", out_valid, 1'b1);
        chk("adv_carry", carry_o,   '0);
        chk("adv_s_data", s_out_data, 8'h78);

        // Multi-cycle madd: two BUBBLE edges, carry tracks carry_i.
        drive(1'b1, 1'b0, 1'b0, 140'hDEAD, 1'b1, 66'h1_0000_0000_0000_0005, 1'b0);
        step();
        chk("bub1_valid",  out_valid,  1'b0);
        chk("bub1_data",   out_data,   '0);
        chk("bub1_carry",  carry_o,    66'h1_0000_0000_0000_0005);
        chk("bub1_cnt",    bubble_cnt, 16'd1);
        chk("bub1_s_data", s_out_data, 8'hA5);
        chk("bub1_s_carry", s_carry_o, '0);
        carry_i = 66'h1_0000_0000_0000_0006;
        step();
        chk("bub2_carry",  carry_o,    66'h1_0000_0000_0000_0006);
        chk("bub2_cnt",    bubble_cnt, 16'd2);
        chk("bub2_hold",   hold_cnt,   16'd0);
        drive(1'b0, 1'b0, 1'b0, 140'hABCD, 1'b0, 66'h3, 1'b0);
        step();
        chk("madd_end_carry", carry_o,   '0);
        chk("madd_end_data",  out_data,  140'hABCD);
        chk("madd_end_valid", out_valid, 1'b0);

        // Flush during hold.
        drive(1'b0, 1'b0, 1'b0, 140'h55, 1'b1, '0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b0, 140'h66, 1'b1, 66'h7, 1'b0);
        step();
        chk("hold_data",  out_data,  140'h55);
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_carry", carry_o,   66'h7);
        chk("hold_cnt",   hold_cnt,  16'd1);
        chk("hold_err",   err_o,     1'b0);
        flush_i = 1'b1;
        step();
        chk("flush_valid",  out_valid,  1'b0);
        chk("flush_data",   out_data,   '0);
        chk("flush_carry",  carry_o,    '0);
        chk("flush_hold",   hold_cnt,   16'd1);
        chk("flush_bubble", bubble_cnt, 16'd2);

        // Flush wins over an illegal stall combination.
        drive(1'b0, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
        step();
        chk("flush_ill_err",  err_o,    1'b0);
        chk("flush_ill_hold", hold_cnt, 16'd1);

        // Illegal stall: payload held, err set, hold counted.
        drive(1'b0, 1'b0, 1'b0, 140'h99, 1'b1, '0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 140'h77, 1'b0, 66'h2A, 1'b0);
        step();
        chk("ill_data",  out_data,  140'h99);
        chk("ill_valid", out_valid, 1'b1);
        chk("ill_err",   err_o,     1'b1);
        chk("ill_hold",  hold_cnt,  16'd2);
        chk("ill_carry", carry_o,   66'h2A);
        // Clear on a further illegal edge: clear wins, payload untouched.
        cnt_clr_i = 1'b1;
        step();
        chk("clr_err",    err_o,      1'b0);
        chk("clr_hold",   hold_cnt,   16'd0);
        chk("clr_bubble", bubble_cnt, 16'd0);
        chk("clr_data",   out_data,   140'h99);
        chk("clr_valid",  out_valid,  1'b1);
        chk("clr_s_hold", s_hold_cnt, 4'd0);

        // Saturation: 20 BUBBLE edges.
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 66'h11, 1'b0);
        for (int i = 0; i < 20; i++) step();
        chk("sat_s_bubble", s_bubble_cnt, 4'd15);
        chk("sat_bubble",   bubble_cnt,   16'd20);
        chk("sat_s_data",   s_out_data,   8'hA5);
        chk("sat_s_carry",  s_carry_o,    '0);
        cnt_clr_i = 1'b1;
        step();
        chk("satclr_s_bubble", s_bubble_cnt, 4'd0);
        chk("satclr_bubble",   bubble_cnt,   16'd0);
        chk("satclr_carry",    carry_o,      66'h11);

        // Async reset while holding a valid payload and carry.
        drive(1'b0, 1'b0, 1'b0, 140'h3C, 1'b1, '0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b0, 140'h0, 1'b0, 66'h9, 1'b0);
        step();
        chk("pre_rst_valid", out_valid, 1'b1);
        chk("pre_rst_carry", carry_o,   66'h9);
        chk("pre_rst_hold",  hold_cnt,  16'd1);
        #1 rst = 1'b1;
        #1;
        chk_reset_state("async_rst");
        rst = 1'b0;

        // No dead cycle after reset release.
        drive(1'b0, 1'b0, 1'b0, 140'h42, 1'b1, '0, 1'b0);
        step();
        chk("post_rst_data",  out_data,  140'h42);
        chk("post_rst_valid", out_valid, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 140, giving the payload width in bits.
REQ-002 The block SHALL have parameter NOP_VALUE, default all-zero of DATA_W, giving the payload value loaded on reset, bubble and flush.
REQ-003 The block SHALL have parameter CARRY_W, default 66, giving the multi-cycle carry width (2-bit count plus 64-bit accumulator).
REQ-004 The block SHALL have parameter CARRY_EN, default 1; when 0, carry_o is constant zero.
REQ-005 The block SHALL have parameter CNT_W, default 16, giving the statistics counter width.
REQ-006 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 in_data  input  DATA_W  payload from upstream stage.
REQ-010 in_valid  input  1  payload qualifies a real instruction.
REQ-011 stall_up  input  1  upstream stage stalled (stage feeding this register).
REQ-012 stall_dn  input  1  downstream stage stalled (stage consuming this register).
REQ-013 flush_i  input  1  exception or redirect flush.
REQ-014 carry_i  input  CARRY_W  multi-cycle operation state from upstream.
REQ-015 cnt_clr_i  input  1  synchronous clear of statistics counters and err_o.
REQ-016 out_data  output  DATA_W  registered payload.
REQ-017 out_valid  output  1  registered valid.
REQ-018 carry_o  output  CARRY_W  registered carry state returned upstream.
REQ-019 bubble_cnt  output  CNT_W  count of bubble cycles.
REQ-020 hold_cnt  output  CNT_W  count of hold cycles.
REQ-021 err_o  output  1  sticky illegal-stall-combination flag.

Function
REQ-022 The block SHALL classify each rising edge by strict priority: FLUSH (flush_i=1) > BUBBLE (stall_up=1, stall_dn=0) > ADVANCE (stall_up=0, stall_dn=0) > HOLD (stall_dn=1).
REQ-023 FLUSH SHALL load out_data=NOP_VALUE, out_valid=0, carry_o=0.
REQ-024 BUBBLE SHALL load out_data=NOP_VALUE, out_valid=0, carry_o=carry_i.
REQ-025 ADVANCE SHALL load out_data=in_data, out_valid=in_valid, carry_o=0.
REQ-026 HOLD SHALL keep out_data and out_valid unchanged and load carry_o=carry_i.
REQ-027 stall_up=0 with stall_dn=1 SHALL be treated as HOLD and SHALL set err_o=1 on that edge.
REQ-028 Latency in ADVANCE SHALL be exactly one cycle from in_data to out_data.
REQ-029 bubble_cnt SHALL increment by 1 on each BUBBLE edge and saturate at 2^CNT_W-1.
REQ-030 hold_cnt SHALL increment by 1 on each HOLD edge and saturate at 2^CNT_W-1.
REQ-031 FLUSH edges SHALL increment neither counter.
REQ-032 cnt_clr_i=1 SHALL zero bubble_cnt, hold_cnt and err_o on that edge, overriding any increment or error set in the same cycle.
REQ-033 cnt_clr_i SHALL NOT affect out_data, out_valid or carry_o.
REQ-034 With CARRY_EN=0, carry_o SHALL be zero in all states and the carry register SHALL NOT be instantiated.

Reset
REQ-035 While rst=1, out_data=NOP_VALUE, out_valid=0, carry_o=0, bubble_cnt=0, hold_cnt=0, err_o=0, independent of clk.
REQ-036 Reset asserted mid-hold or mid-multi-cycle operation SHALL discard held payload and carry immediately.
REQ-037 After rst deasserts, the first rising edge SHALL be classified per REQ-022 with no extra dead cycle.

Verification
REQ-038 Advance: in_data=0x1234_5678 (low bits, rest 0), in_valid=1, stalls 0 -> out_data equals that value, out_valid=1, carry_o=0 one edge later.
REQ-039 Multi-cycle madd: stall_up=1, stall_dn=0 for 2 edges, carry_i=0x1_0000_0000_0000_0005 -> out_valid=0, out_data=NOP_VALUE, carry_o tracks carry_i, bubble_cnt=2; then stalls 0 -> carry_o=0.
REQ-040 Flush during hold: stall_dn=1, stall_up=1, out_valid=1, then flush_i=1 -> out_valid=0, carry_o=0, hold_cnt unchanged by the flush edge.
REQ-041 Illegal stall: stall_up=0, stall_dn=1 -> out_data unchanged, err_o=1, hold_cnt+1; cnt_clr_i=1 next edge -> err_o=0, counters 0.
REQ-042 Saturation, CNT_W=4: 20 BUBBLE edges -> bubble_cnt=15; cnt_clr_i together with a BUBBLE edge -> bubble_cnt=0.
REQ-043 Async reset: assert rst between clock edges while out_valid=1 -> all outputs reach reset values before the next rising edge.
